// File: rtl/grid_gp_inpad_top_sync.sv
`default_nettype none
// ============================================================================
// Module   : grid_gp_inpad_top_sync
// Brief    : GP pad-ring input tile. It synchronises the pads, optionally debounces
//            them (GP_INPAD_DEBOUNCE_EN), strobes edges and accumulates edge events.
// Revision : 1.0 - initial release
// ============================================================================
module grid_gp_inpad_top_sync #(
  parameter int NUM_PADS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_PADS-1:0] gfpga_pad_GPIN_PAD,
  input  logic                enable,
  output logic [NUM_PADS-1:0] pin_inpad,
  output logic [NUM_PADS-1:0] rise_pulse,
  output logic [NUM_PADS-1:0] fall_pulse,
  output logic                evt_valid,
  output logic [NUM_PADS-1:0] evt_mask,
  input  logic                evt_ack,
  output logic                evt_overflow
);

  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] w_sync;
  logic [NUM_PADS-1:0] pin_q;
  logic [NUM_PADS-1:0] pin_d;
  logic [NUM_PADS-1:0] rise_q;
  logic [NUM_PADS-1:0] fall_q;
  logic [NUM_PADS-1:0] mask_q;
  logic [NUM_PADS-1:0] mask_d;
  logic                valid_q;
  logic                ovf_q;
  logic                ovf_d;
  logic [NUM_PADS-1:0] w_edge;
  logic                w_ack_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gfpga_pad_GPIN_PAD;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

`ifdef GP_INPAD_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NUM_PADS];
  logic [CNT_W-1:0] cnt_d [NUM_PADS];

  // The level commits on the DEBOUNCE_CYCLES-th consecutive differing sample,
  // so the counter tops out at DEBOUNCE_CYCLES-1 and never wraps.
  always_comb begin
    pin_d = pin_q;
    for (int i = 0; i < NUM_PADS; i++) begin
      cnt_d[i] = '0;
      if (enable && (w_sync[i] != pin_q[i])) begin
        if (cnt_q[i] == C_CNT_LAST) begin
          pin_d[i] = w_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = CNT_W + DEBOUNCE_CYCLES;
  assign pin_d      = enable ? w_sync : pin_q;
`endif

  // Edges seen in an ack cycle start the new event word instead of being dropped.
  assign w_edge    = rise_q | fall_q;
  assign w_ack_acc = evt_ack & valid_q;
  assign mask_d    = w_ack_acc ? w_edge : (mask_q | w_edge);
  assign ovf_d     = ~w_ack_acc & (ovf_q | (|(w_edge & mask_q)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pin_q   <= pin_d;
      rise_q  <= pin_d & ~pin_q;
      fall_q  <= ~pin_d & pin_q;
      mask_q  <= mask_d;
      valid_q <= |mask_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pin_inpad    = pin_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign evt_mask     = mask_q;
  assign evt_valid    = valid_q;
  assign evt_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_gp_inpad_top_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_gp_inpad_top_sync
// Brief    : Self-checking bench for grid_gp_inpad_top_sync with a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_gp_inpad_top_sync;

  localparam int NP   = 8;
  localparam int SYNC = 2;
  localparam int DB   = 4;
`ifdef GP_INPAD_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int LAT = DB_EN ? (SYNC + DB) : (SYNC + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] pads;
  logic          enable;
  logic          evt_ack;
  logic [NP-1:0] pin_inpad, rise_pulse, fall_pulse, evt_mask;
  logic          evt_valid, evt_overflow;

  int n_checks = 0;
  int n_errors = 0;

  grid_gp_inpad_top_sync #(
    .NUM_PADS        (NP),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (8)
  ) u_dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .gfpga_pad_GPIN_PAD (pads),
    .enable             (enable),
    .pin_inpad          (pin_inpad),
    .rise_pulse         (rise_pulse),
    .fall_pulse         (fall_pulse),
    .evt_valid          (evt_valid),
    .evt_mask           (evt_mask),
    .evt_ack            (evt_ack),
    .evt_overflow       (evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin follows the synchronised pad once it has differed
  // for DB consecutive enabled samples (or every enabled cycle without debounce).
  logic [NP-1:0] m_pin, m_rise, m_fall, m_mask;
  logic          m_valid, m_ovf;
  logic [NP-1:0] pad_hist [$];
  logic [NP-1:0] s_hist   [$];
  bit            en_hist  [$];

  task automatic model_reset();
    m_pin = '0; m_rise = '0; m_fall = '0; m_mask = '0;
    m_valid = 1'b0; m_ovf = 1'b0;
    pad_hist.delete(); s_hist.delete(); en_hist.delete();
    for (int k = 0; k < SYNC; k++) pad_hist.push_back('0);
  endtask

  task automatic model_step();
    logic [NP-1:0] s, nxt, e;
    bit ok, acc;
    s = pad_hist[pad_hist.size() - SYNC];
    pad_hist.push_back(pads);
    if (pad_hist.size() > SYNC) void'(pad_hist.pop_front());
    s_hist.push_back(s);
    en_hist.push_back(enable);
    if (s_hist.size() > DB) begin
      void'(s_hist.pop_front());
      void'(en_hist.pop_front());
    end
    nxt = m_pin;
    if (DB_EN) begin
      for (int i = 0; i < NP; i++) begin
        ok = (en_hist.size() == DB);
        for (int k = 0; k < en_hist.size(); k++)
          if (!en_hist[k] || (s_hist[k][i] == m_pin[i])) ok = 0;
        if (ok) nxt[i] = s[i];
      end
    end else if (enable) begin
      nxt = s;
    end
    e   = m_rise | m_fall;
    acc = evt_ack && m_valid;
    if (acc) begin
      m_mask = e;
      m_ovf  = 1'b0;
    end else begin
      if ((e & m_mask) != '0) m_ovf = 1'b1;
      m_mask = m_mask | e;
    end
    m_valid = (m_mask != '0);
    m_rise  = nxt & ~m_pin;
    m_fall  = ~nxt & m_pin;
    m_pin   = nxt;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check_eq("pin_inpad",    pin_inpad,    m_pin);
      check_eq("rise_pulse",   rise_pulse,   m_rise);
      check_eq("fall_pulse",   fall_pulse,   m_fall);
      check_eq("evt_mask",     evt_mask,     m_mask);
      check_eq("evt_valid",    evt_valid,    m_valid);
      check_eq("evt_overflow", evt_overflow, m_ovf);
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pin"},   pin_inpad,    '0);
    check_eq({tag, "_rise"},  rise_pulse,   '0);
    check_eq({tag, "_fall"},  fall_pulse,   '0);
    check_eq({tag, "_mask"},  evt_mask,     '0);
    check_eq({tag, "_valid"}, evt_valid,    '0);
    check_eq({tag, "_ovf"},   evt_overflow, '0);
  endtask

  task automatic do_ack();
    @(negedge clk) evt_ack = 1'b1;
    @(negedge clk) evt_ack = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  cnt;
  bit  found;
  logic [NP-1:0] acc_edges;

  initial begin
    model_reset();
    reset_n = 1'b0; pads = '1; enable = 1'b1; evt_ack = 1'b0;

    // Pads high through reset, then release and measure latency.
    wait_neg(3);
    check_all_zero("t1_reset");
    reset_n = 1'b1;
    cnt = 0; found = 0;
    while (cnt < 40 && !found) begin
      @(posedge clk); #1;
      cnt++;
      if (pin_inpad == '1) found = 1;
    end
    check_eq("t1_latency",   cnt, LAT);
    check_eq("t1_rise",      rise_pulse, 8'hFF);
    @(posedge clk); #1;
    check_eq("t1_valid",     evt_valid, 1'b1);
    check_eq("t1_mask",      evt_mask, 8'hFF);
    check_eq("t1_rise_gone", rise_pulse, 8'h00);

    // Short pad0 pulse.
    @(negedge clk) pads = '0;
    wait_neg(12);
    do_ack();
    wait_neg(2);
    pads[0] = 1'b1;
    wait_neg(3);
    pads[0] = 1'b0;
    wait_neg(12);
    check_eq("t2_pin0", pin_inpad[0], 1'b0);
    check_eq("t2_mask", evt_mask, DB_EN ? 8'h00 : 8'h01);
    check_eq("t2_ovf",  evt_overflow, DB_EN ? 1'b0 : 1'b1);

    // Ack coinciding with pad3 rise strobe.
    do_ack();
    wait_neg(2);
    pads[0] = 1'b1;
    wait_neg(12);
    check_eq("t3_mask_pre", evt_mask, 8'h01);
    pads[3] = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (rise_pulse[3]) found = 1;
    end
    check_eq("t3_rise_seen", found, 1'b1);
    evt_ack = 1'b1;
    @(posedge clk); #1;
    evt_ack = 1'b0;
    check_eq("t3_mask",  evt_mask, 8'h08);
    check_eq("t3_valid", evt_valid, 1'b1);
    check_eq("t3_ovf",   evt_overflow, 1'b0);

    // Rise then fall on pad2 without ack.
    do_ack();
    wait_neg(2);
    pads[2] = 1'b1;
    wait_neg(12);
    pads[2] = 1'b0;
    wait_neg(12);
    check_eq("t4_mask",  evt_mask, 8'h04);
    check_eq("t4_ovf",   evt_overflow, 1'b1);
    do_ack();
    wait_neg(2);
    check_eq("t4_valid_after_ack", evt_valid, 1'b0);
    check_eq("t4_ovf_after_ack",   evt_overflow, 1'b0);

    // One-clock glitch on pad5.
    pads[5] = 1'b1;
    wait_neg(1);
    pads[5] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pin_inpad[5]) cnt++;
    end
    check_eq("t5_glitch_width", cnt, DB_EN ? 0 : 1);
    do_ack();
    wait_neg(2);

    // Async reset mid-debounce with a pending event word and overflow.
    pads[0] = 1'b0;
    wait_neg(12);
    pads[4] = 1'b1;
    wait_neg(12);
    pads[4] = 1'b0;
    wait_neg(12);
    check_eq("t6_mask_pre", evt_mask, 8'h11);
    check_eq("t6_ovf_pre",  evt_overflow, 1'b1);
    pads[1] = 1'b1;
    wait_neg(2);
    #2 reset_n = 1'b0;
    #1 check_all_zero("t6_async");
    pads = '0;
    wait_neg(3);
    reset_n = 1'b1;
    acc_edges = '0;
    repeat (20) begin
      @(posedge clk); #1;
      acc_edges = acc_edges | rise_pulse | fall_pulse;
    end
    check_eq("t6_no_spurious", acc_edges, 8'h00);

    // Randomised traffic with enable drops, acks and one async reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++)
        if ($urandom_range(15) == 0) pads[i] = ~pads[i];
      if ($urandom_range(39) == 0) enable = ~enable;
      evt_ack = ($urandom_range(3) == 0);
      if (cyc == 1500) begin
        #3 reset_n = 1'b0;
        #1 check_all_zero("rnd_async");
        @(negedge clk) reset_n = 1'b1;
      end
    end
    evt_ack = 1'b0;
    wait_neg(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
